alu_responder: RTL and testbench

- Request/response execution unit: accepts ALU operation requests (a, b, alufun, sign, tag) over a valid/ready handshake and returns registered results in order.
- Responder side of the ALU command interface; replaces free-running combinational drive of the ALU with a flow-controlled, 2-cycle-latency service.
- Sits between the issue logic (or a bench driver) and the writeback/compare path.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_core.sv | 61 ++++++
 rtl/alu_responder.sv | 141 ++++++++++++++
 tb/tb_alu_responder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU responder: datapath widths, function codes and a
// small helper that widens a compare flag to a full result word.
package alu_pkg;
    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    localparam logic [5:0] ALU_ADD  = 6'b000000;
    localparam logic [5:0] ALU_SUB  = 6'b000001;
    localparam logic [5:0] ALU_AND  = 6'b011000;
    localparam logic [5:0] ALU_OR   = 6'b011110;
    localparam logic [5:0] ALU_XOR  = 6'b010110;
    localparam logic [5:0] ALU_NOR  = 6'b010001;
    localparam logic [5:0] ALU_A    = 6'b011010;
    localparam logic [5:0] ALU_SLL  = 6'b100000;
    localparam logic [5:0] ALU_SRL  = 6'b100001;
    localparam logic [5:0] ALU_SRA  = 6'b100011;
    localparam logic [5:0] ALU_EQ   = 6'b110011;
    localparam logic [5:0] ALU_NEQ  = 6'b110001;
    localparam logic [5:0] ALU_LT   = 6'b110101;
    localparam logic [5:0] ALU_LEZ  = 6'b111101;
    localparam logic [5:0] ALU_LTZ  = 6'b111011;
    localparam logic [5:0] ALU_GTZ  = 6'b111111;

    function automatic logic [DATA_W-1:0] flag_word(input logic f);
        return {{(DATA_W-1){1'b0}}, f};
    endfunction
endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU evaluator: result, ADD/SUB overflow (signed) or
// carry/borrow (unsigned), and an error flag for unrecognised function codes.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [5:0]        alufun,
    input  logic              sign,
    output logic [DATA_W-1:0] res,
    output logic              ovf,
    output logic              err
);
    logic [DATA_W:0]    sum_ext;
    logic [DATA_W:0]    diff_ext;
    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;
    logic               a_zero;

    // Extra top bit of the widened add/sub is the carry-out / borrow.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
    assign shamt    = a[SHAMT_W-1:0];
    assign lt_s     = $signed(a) < $signed(b);
    assign lt_u     = a < b;
    assign a_zero   = (a == '0);

    always_comb begin
        res = '0;
        ovf = 1'b0;
        err = 1'b0;
        case (alufun)
            ALU_ADD: begin
                res = sum_ext[DATA_W-1:0];
                ovf = sign ? ((a[DATA_W-1] == b[DATA_W-1]) && (sum_ext[DATA_W-1] != a[DATA_W-1]))
                           : sum_ext[DATA_W];
            end
            ALU_SUB: begin
                res = diff_ext[DATA_W-1:0];
                ovf = sign ? ((a[DATA_W-1] != b[DATA_W-1]) && (diff_ext[DATA_W-1] != a[DATA_W-1]))
                           : diff_ext[DATA_W];
            end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_NOR: res = ~(a | b);
            ALU_A:   res = a;
            ALU_SLL: res = b << shamt;
            ALU_SRL: res = b >> shamt;
            ALU_SRA: res = DATA_W'($signed(b) >>> shamt);
            ALU_EQ:  res = flag_word(a == b);
            ALU_NEQ: res = flag_word(a != b);
            ALU_LT:  res = flag_word(sign ? lt_s : lt_u);
            ALU_LEZ: res = flag_word(a[DATA_W-1] || a_zero);
            ALU_LTZ: res = flag_word(a[DATA_W-1]);
            ALU_GTZ: res = flag_word(!a[DATA_W-1] && !a_zero);
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_responder.sv
// Flow-controlled ALU service: one stage-1 operand register feeding alu_core,
// then an in-order response FIFO whose head drives the resp_* outputs.
module alu_responder
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [5:0]        req_alufun,
    input  logic              req_sign,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_res,
    output logic              resp_ovf,
    output logic              resp_err,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [15:0]       op_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [5:0]        s1_fun_q, s1_fun_d;
    logic              s1_sign_q, s1_sign_d;
    logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       op_count_q, op_count_d;

    logic [DATA_W-1:0] mem_res_q [DEPTH];
    logic              mem_ovf_q [DEPTH];
    logic              mem_err_q [DEPTH];
    logic [TAG_W-1:0]  mem_tag_q [DEPTH];

    logic [DATA_W-1:0] core_res;
    logic              core_ovf;
    logic              core_err;
    logic [CNT_W:0]    occupancy;
    logic              accept;
    logic              push;
    logic              pop;

    // The stage-1 slot counts as occupied so the push it makes next cycle
    // always has a free FIFO entry; a same-cycle pop earns no credit.
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q};
    assign req_ready  = occupancy < DEPTH_C;
    assign accept     = req_valid && req_ready;
    assign push       = s1_valid_q;
    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;

    alu_core u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .alufun (s1_fun_q),
        .sign   (s1_sign_q),
        .res    (core_res),
        .ovf    (core_ovf),
        .err    (core_err)
    );

    always_comb begin
        s1_valid_d = accept;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_fun_d   = s1_fun_q;
        s1_sign_d  = s1_sign_q;
        s1_tag_d   = s1_tag_q;
        if (accept) begin
            s1_a_d    = req_a;
            s1_b_d    = req_b;
            s1_fun_d  = req_alufun;
            s1_sign_d = req_sign;
            s1_tag_d  = req_tag;
        end

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        op_count_d = op_count_q + 16'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_fun_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_tag_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            op_count_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_fun_q   <= s1_fun_d;
            s1_sign_q  <= s1_sign_d;
            s1_tag_q   <= s1_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_count_q <= op_count_d;
        end
    end

    // Storage needs no reset: the head is only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_res_q[wr_ptr_q] <= core_res;
            mem_ovf_q[wr_ptr_q] <= core_ovf;
            mem_err_q[wr_ptr_q] <= core_err;
            mem_tag_q[wr_ptr_q] <= s1_tag_q;
        end
    end

    assign resp_res = resp_valid ? mem_res_q[rd_ptr_q] : '0;
    assign resp_ovf = resp_valid ? mem_ovf_q[rd_ptr_q] : 1'b0;
    assign resp_err = resp_valid ? mem_err_q[rd_ptr_q] : 1'b0;
    assign resp_tag = resp_valid ? mem_tag_q[rd_ptr_q] : '0;
    assign op_count = op_count_q;
endmodule

// File: tb/tb_alu_responder.sv
// Scoreboard bench for alu_responder: directed vectors with fixed expectations,
// then randomized traffic checked against an arithmetic reference model.
module tb_alu_responder;
    localparam int TAG_W = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic             err;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [5:0]       req_alufun;
    logic             req_sign;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_res;
    logic             resp_ovf;
    logic             resp_err;
    logic [TAG_W-1:0] resp_tag;
    logic [15:0]      op_count;

    int   total = 0;
    int   bad = 0;
    int   pop_cnt = 0;
    int   rdy_mode = 1;
    exp_t exp_q[$];

    alu_responder #(.DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_alufun (req_alufun),
        .req_sign   (req_sign),
        .req_tag    (req_tag),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_res   (resp_res),
        .resp_ovf   (resp_ovf),
        .resp_err   (resp_err),
        .resp_tag   (resp_tag),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] res, input logic ovf, input logic err,
                                input logic [TAG_W-1:0] tag);
        exp_t e;
        e.res = res; e.ovf = ovf; e.err = err; e.tag = tag;
        return e;
    endfunction

    // Reference model: results from plain 64-bit arithmetic on the operand values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                                   input logic s, input logic [TAG_W-1:0] t);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint r;
        exp_t   e = mk(32'h0, 1'b0, 1'b0, t);
        case (f)
            6'b000000: begin
                e.res = a + b;
                r = sa + sb;
                e.ovf = s ? (r > SMAX || r < SMIN) : (ua + ub > 64'sd4294967295);
            end
            6'b000001: begin
                e.res = a - b;
                r = sa - sb;
                e.ovf = s ? (r > SMAX || r < SMIN) : (ua < ub);
            end
            6'b011000: e.res = a & b;
            6'b011110: e.res = a | b;
            6'b010110: e.res = a ^ b;
            6'b010001: e.res = ~(a | b);
            6'b011010: e.res = a;
            6'b100000: e.res = b << a[4:0];
            6'b100001: e.res = b >> a[4:0];
            6'b100011: e.res = 32'(sb >>> a[4:0]);
            6'b110011: e.res = (a == b) ? 32'h1 : 32'h0;
            6'b110001: e.res = (a != b) ? 32'h1 : 32'h0;
            6'b110101: e.res = (s ? (sa < sb) : (ua < ub)) ? 32'h1 : 32'h0;
            6'b111101: e.res = (sa <= 0) ? 32'h1 : 32'h0;
            6'b111011: e.res = (sa < 0) ? 32'h1 : 32'h0;
            6'b111111: e.res = (sa > 0) ? 32'h1 : 32'h0;
            default:   e.err = 1'b1;
        endcase
        return e;
    endfunction

    // resp_ready: 0 = stalled, 1 = always ready, 2 = random.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       resp_ready = 1'b0;
            1:       resp_ready = 1'b1;
            default: resp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pops the scoreboard whenever the DUT hands over a response.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pop_cnt = 0;
        end else if (resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got tag %0h res %0h, required no response",
                         resp_tag, resp_res);
            end else begin
                e = exp_q.pop_front();
                check("resp", 64'({resp_err, resp_ovf, resp_tag, resp_res}), 64'(e));
                check("op_count_at_pop", 64'(op_count), 64'(pop_cnt[15:0]));
                pop_cnt++;
            end
        end
    end

    // Drives one request until accepted or max_cyc cycles expire; on acceptance
    // pushes either the supplied fixed expectation or the model's.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                        input logic s, input logic [TAG_W-1:0] t, input int max_cyc,
                        input bit use_fixed, input exp_t fixed, output bit acc);
        req_valid = 1'b1; req_a = a; req_b = b; req_alufun = f; req_sign = s; req_tag = t;
        acc = 1'b0;
        for (int c = 0; c < max_cyc && !acc; c++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                exp_q.push_back(use_fixed ? fixed : model(a, b, f, s, t));
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || resp_valid) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'hFFFFFFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic        s;
        exp_t        e;
    } vec_t;

    initial begin
        bit          acc;
        int          n_acc;
        vec_t        vecs[$];
        logic [5:0]  codes[16];
        logic [5:0]  f;

        codes = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                  6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                  6'b110101, 6'b111101, 6'b111011, 6'b111111};

        reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_alufun = '0; req_sign = 1'b0; req_tag = '0; rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_fields", 64'({resp_err, resp_ovf, resp_tag, resp_res}), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // Single ADD: visible two rising edges after it is first driven.
        send(32'd5, 32'd8, 6'b000000, 1'b1, 4'h3, 1, 1'b1, mk(32'd13, 1'b0, 1'b0, 4'h3), acc);
        check("add_accept", 64'(acc), 64'd1);
        @(negedge clk);
        check("lat_not_yet", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("lat_valid", 64'(resp_valid), 64'd1);
        check("add_res", 64'(resp_res), 64'd13);
        @(posedge clk); #1;
        check("add_op_count", 64'(op_count), 64'd1);

        // Back-to-back directed vectors; each must be taken on its first cycle.
        vecs.push_back('{32'd5, 32'd8, 6'b000001, 1'b1, mk(32'hFFFFFFFD, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'd5, 32'd8, 6'b110101, 1'b1, mk(32'h1, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 6'b110101, 1'b0, mk(32'h0, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'd4, 32'h80000000, 6'b100011, 1'b0, mk(32'hF8000000, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'd0, 32'd0, 6'b010001, 1'b0, mk(32'hFFFFFFFF, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'h7FFFFFFF, 32'd1, 6'b000000, 1'b1, mk(32'h80000000, 1'b1, 1'b0, 0)});
        vecs.push_back('{32'hFFFFFFFF, 32'd1, 6'b000000, 1'b0, mk(32'h0, 1'b1, 1'b0, 0)});
        vecs.push_back('{32'd9, 32'd9, 6'b101010, 1'b0, mk(32'h0, 1'b0, 1'b1, 0)});
        vecs.push_back('{32'd0, 32'd1, 6'b000001, 1'b0, mk(32'hFFFFFFFF, 1'b1, 1'b0, 0)});
        vecs.push_back('{32'h80000000, 32'd1, 6'b000001, 1'b1, mk(32'h7FFFFFFF, 1'b1, 1'b0, 0)});
        vecs.push_back('{32'd31, 32'd1, 6'b100000, 1'b0, mk(32'h80000000, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'd4, 32'h80000000, 6'b100001, 1'b0, mk(32'h08000000, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'd0, 32'd0, 6'b111101, 1'b0, mk(32'h1, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'h80000000, 32'd0, 6'b111111, 1'b0, mk(32'h0, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'h80000000, 32'd0, 6'b111011, 1'b0, mk(32'h1, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'd7, 32'd7, 6'b110011, 1'b0, mk(32'h1, 1'b0, 1'b0, 0)});
        vecs.push_back('{32'h1234ABCD, 32'd7, 6'b011010, 1'b0, mk(32'h1234ABCD, 1'b0, 1'b0, 0)});
        for (int i = 0; i < vecs.size(); i++) begin
            vecs[i].e.tag = 4'(i);
            send(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].s, 4'(i), 1, 1'b1, vecs[i].e, acc);
            check("stream_accept", 64'(acc), 64'd1);
        end
        drain("stream_drain");

        // Stall: with resp_ready low, exactly DEPTH requests fit.
        reset = 1'b1; exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; rdy_mode = 0;
        @(posedge clk); #1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(32'(i), 32'd100, 6'b000000, 1'b0, 4'(i), (i < 4) ? 1 : 6, 1'b1,
                 mk(32'(i + 100), 1'b0, 1'b0, 4'(i)), acc);
            n_acc += int'(acc);
        end
        check("stall_accepted", 64'(n_acc), 64'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req_ready", 64'(req_ready), 64'd0);
            check("stall_head", 64'({resp_valid, resp_tag, resp_res}), 64'({1'b1, 4'h0, 32'd100}));
        end
        @(posedge clk); #1;
        rdy_mode = 1;
        for (int i = 4; i < 6; i++) begin
            send(32'(i), 32'd100, 6'b000000, 1'b0, 4'(i), 10, 1'b1,
                 mk(32'(i + 100), 1'b0, 1'b0, 4'(i)), acc);
            check("resume_accept", 64'(acc), 64'd1);
        end
        drain("stall_drain");
        check("stall_op_count", 64'(op_count), 64'd6);

        // Reset with three responses queued and one in stage 1.
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            send(32'(i), 32'd1, 6'b011110, 1'b0, 4'(i + 8), 1, 1'b0, mk(0, 0, 0, 0), acc);
            check("prefill_accept", 64'(acc), 64'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        check("midrst_op_count", 64'(op_count), 64'd0);
        check("midrst_fields", 64'({resp_err, resp_ovf, resp_tag, resp_res}), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0; rdy_mode = 1;
        @(negedge clk);
        check("postrst_req_ready", 64'(req_ready), 64'd1);
        check("postrst_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        send(32'd20, 32'd3, 6'b000001, 1'b1, 4'hA, 1, 1'b1, mk(32'd17, 1'b0, 1'b0, 4'hA), acc);
        check("postrst_accept", 64'(acc), 64'd1);
        @(negedge clk);
        check("postrst_lat_not_yet", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("postrst_lat_valid", 64'(resp_valid), 64'd1);
        drain("postrst_drain");

        // Randomized traffic with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : codes[$urandom_range(0, 15)];
            send(rnd_op(), rnd_op(), f, 1'($urandom_range(0, 1)), 4'($urandom), 64, 1'b0,
                 mk(0, 0, 0, 0), acc);
            if (!acc) check("rand_accept_timeout", 64'(acc), 64'd1);
        end
        rdy_mode = 1;
        drain("rand_drain");
        check("rand_op_count", 64'(op_count), 64'(pop_cnt[15:0]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
